// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared types for the AHB master request controller: transfer encodings and FSM states.
package ahb_master_req_ctrl_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBurst,
    StRelease
  } req_state_t;

  // True while the controller owns (or is asking for) the bus.
  function automatic logic is_active(req_state_t st);
    return (st == StReq) || (st == StBurst);
  endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_if.sv
// Command port plus arbiter handshake of one bus master; master modport is the controller side.
interface ahb_master_req_ctrl_if
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              hreq;
  logic              hlast;
  logic              hgrant;
  logic [ADDR_W-1:0] haddr;
  htrans_t           htrans;
  logic              beat_acc;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, hgrant,
    output cmd_ready, hreq, hlast, haddr, htrans, beat_acc, done, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, hgrant,
    input  cmd_ready, hreq, hlast, haddr, htrans, beat_acc, done, err
  );

endinterface

// File: rtl/ahb_req_watchdog.sv
// Request watchdog: counts ungranted REQ cycles and flags the cycle that reaches the limit.
module ahb_req_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic hclk,
  input  logic hreset_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the stall cycle that would bring the count to the limit.
  assign tc = inc && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// AHB master-side burst requester: accepts commands, requests the bus, sequences beats.
// Optional request watchdog enabled by defining AHB_REQ_TIMEOUT_EN.
module ahb_master_req_ctrl
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned BEAT_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                  hclk,
  input logic                  hreset_n,
  ahb_master_req_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] BeatStep = ADDR_W'(BEAT_BYTES);

  req_state_t        state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              active;
  logic              abort;

  assign active = is_active(state_q);

  always_comb begin
    state_d = state_q;
    haddr_d = haddr_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          haddr_d = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = StReq;
        end
      end
      StReq, StBurst: begin
        if (bus.hgrant) begin
          if (rem_q == '0) begin
            state_d = StRelease;
          end else begin
            rem_d   = rem_q - LEN_W'(1);
            haddr_d = haddr_q + BeatStep;
            state_d = StBurst;
          end
        end else if (abort) begin
          state_d = StIdle;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= StIdle;
      haddr_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      haddr_q <= haddr_d;
      rem_q   <= rem_d;
    end
  end

`ifdef AHB_REQ_TIMEOUT_EN
  logic wd_tc;
  logic err_q;

  // Only the initial request is watched; once granted, the arbiter owns pacing.
  ahb_req_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .hclk    (hclk),
    .hreset_n(hreset_n),
    .clr     (state_q != StReq),
    .inc     ((state_q == StReq) && !bus.hgrant),
    .tc      (wd_tc)
  );

  assign abort = wd_tc;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign bus.err        = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.hreq      = active;
  assign bus.hlast     = active && (rem_q == '0);
  assign bus.haddr     = haddr_q;
  assign bus.done      = (state_q == StRelease);
  // Grants outside REQ/BURST are protocol errors and never count as beats.
  assign bus.beat_acc  = bus.hgrant && active;

  always_comb begin
    bus.htrans = HtransIdle;
    if (state_q == StReq) begin
      bus.htrans = HtransNonseq;
    end else if (state_q == StBurst) begin
      bus.htrans = HtransSeq;
    end
  end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Directed self-checking bench for ahb_master_req_ctrl.
module tb_ahb_master_req_ctrl;
  import ahb_master_req_ctrl_pkg::*;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned BEAT_BYTES = 4;

  logic hclk     = 1'b0;
  logic hreset_n = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  int   d0;

  ahb_master_req_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  ahb_master_req_ctrl #(
    .ADDR_W        (ADDR_W),
    .LEN_W         (LEN_W),
    .BEAT_BYTES    (BEAT_BYTES),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .hclk    (hclk),
    .hreset_n(hreset_n),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) begin
    if (hreset_n) begin
      if (bus.beat_acc) acc_cnt <= acc_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic grant_beat(input logic [31:0] a, input logic [1:0] tr, input logic last);
    bus.hgrant = 1'b1;
    #1;
    chk("beat_hreq", bus.hreq, 1);
    chk("beat_haddr", bus.haddr, a);
    chk("beat_htrans", bus.htrans, tr);
    chk("beat_hlast", bus.hlast, last);
    chk("beat_acc", bus.beat_acc, 1);
    tick();
  endtask

  task automatic stall(input logic [31:0] a, input logic [1:0] tr, input logic last, input int n);
    repeat (n) begin
      bus.hgrant = 1'b0;
      #1;
      chk("stall_hreq", bus.hreq, 1);
      chk("stall_haddr", bus.haddr, a);
      chk("stall_htrans", bus.htrans, tr);
      chk("stall_hlast", bus.hlast, last);
      chk("stall_beat_acc", bus.beat_acc, 0);
      tick();
    end
  endtask

  task automatic burst(input logic [31:0] a, input logic [3:0] len, input int stall_idx,
                       input int stall_n, input bit keep_valid);
    logic [31:0] last_a;
    logic [31:0] ea;
    int          a0;
    int          dd0;
    last_a = a + 32'(len) * BEAT_BYTES;
    if ((a >> 10) != (last_a >> 10)) begin
      $display("FAIL page_cross: command 0x%0h len %0d crosses 1KB", a, len);
      $fatal(1, "illegal command");
    end
    bus.hgrant    = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    #1;
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_hreq", bus.hreq, 0);
    tick();
    if (!keep_valid) bus.cmd_valid = 1'b0;
    a0  = acc_cnt;
    dd0 = done_cnt;
    #1;
    chk("req_cmd_ready", bus.cmd_ready, 0);
    for (int i = 0; i <= int'(len); i++) begin
      ea = a + 32'(i) * BEAT_BYTES;
      if (i == stall_idx) stall(ea, (i == 0) ? 2'b10 : 2'b11, i == int'(len), stall_n);
      grant_beat(ea, (i == 0) ? 2'b10 : 2'b11, i == int'(len));
    end
    // Grant held high into RELEASE must be ignored.
    bus.hgrant = 1'b1;
    #1;
    chk("rel_done", bus.done, 1);
    chk("rel_hreq", bus.hreq, 0);
    chk("rel_htrans", bus.htrans, 0);
    chk("rel_hlast", bus.hlast, 0);
    chk("rel_beat_acc", bus.beat_acc, 0);
    chk("rel_cmd_ready", bus.cmd_ready, 0);
    chk("rel_err", bus.err, 0);
    tick();
    bus.hgrant = 1'b0;
    #1;
    chk("post_done", bus.done, 0);
    chk("post_cmd_ready", bus.cmd_ready, 1);
    chk("post_hreq", bus.hreq, 0);
    chk("post_beats", acc_cnt - a0, int'(len) + 1);
    chk("post_done_cnt", done_cnt - dd0, 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.hgrant    = 1'b0;
    @(negedge hclk);
    #1;
    chk("rst_hreq", bus.hreq, 0);
    chk("rst_hlast", bus.hlast, 0);
    chk("rst_htrans", bus.htrans, 0);
    chk("rst_haddr", bus.haddr, 0);
    chk("rst_beat_acc", bus.beat_acc, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    @(negedge hclk);
    hreset_n = 1'b1;
    tick();
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // Grant while idle is a protocol error: no beat, stays idle.
    bus.hgrant = 1'b1;
    #1;
    chk("idle_grant_acc", bus.beat_acc, 0);
    tick();
    #1;
    chk("idle_grant_hreq", bus.hreq, 0);
    chk("idle_grant_ready", bus.cmd_ready, 1);

    // Single beat, grant two cycles after request.
    burst(32'h100, 4'd0, 0, 2, 1'b0);
    // Four beats, no waits.
    burst(32'h200, 4'd3, -1, 0, 1'b0);
    // Four beats, three wait cycles while 0x204 is presented.
    burst(32'h200, 4'd3, 1, 3, 1'b0);
    // Back-to-back with cmd_valid held high across both.
    burst(32'h280, 4'd1, -1, 0, 1'b1);
    burst(32'h2C0, 4'd2, 1, 1, 1'b0);

    // Reset during beat 3 of an eight-beat burst.
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h300;
    bus.cmd_len   = 4'd7;
    #1;
    tick();
    bus.cmd_valid = 1'b0;
    grant_beat(32'h300, 2'b10, 1'b0);
    grant_beat(32'h304, 2'b11, 1'b0);
    d0 = done_cnt;
    bus.hgrant = 1'b1;
    #1;
    chk("mid_haddr", bus.haddr, 32'h308);
    hreset_n = 1'b0;
    #1;
    chk("arst_hreq", bus.hreq, 0);
    chk("arst_htrans", bus.htrans, 0);
    chk("arst_haddr", bus.haddr, 0);
    chk("arst_hlast", bus.hlast, 0);
    chk("arst_beat_acc", bus.beat_acc, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_err", bus.err, 0);
    bus.hgrant = 1'b0;
    tick();
    tick();
    hreset_n = 1'b1;
    tick();
    chk("arst_no_done", done_cnt, d0);
    burst(32'h400, 4'd2, -1, 0, 1'b0);

`ifdef AHB_REQ_TIMEOUT_EN
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h500;
    bus.cmd_len   = 4'd0;
    bus.hgrant    = 1'b0;
    #1;
    tick();
    bus.cmd_valid = 1'b0;
    d0 = done_cnt;
    repeat (8) begin
      #1;
      chk("to_wait_hreq", bus.hreq, 1);
      chk("to_wait_err", bus.err, 0);
      tick();
    end
    #1;
    chk("to_err", bus.err, 1);
    chk("to_hreq", bus.hreq, 0);
    chk("to_cmd_ready", bus.cmd_ready, 1);
    tick();
    #1;
    chk("to_err_pulse", bus.err, 0);
    chk("to_no_done", done_cnt, d0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
